// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment pattern constants and nibble lookup for the scan driver
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Active-low, bit order g..a
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1011000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t seg7_lookup(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_dec_core.sv
// rtl/seg7_dec_core.sv - nibble + blank to active-low segments; SEG7_HEX_EN enables A-F glyphs
module seg7_dec_core
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] n_seg
);

    always_comb begin
        n_seg = SEG_BLANK;
        if (!blank) begin
`ifdef SEG7_HEX_EN
            n_seg = seg7_lookup(nib);
`else
            if (nib <= 4'd9) begin
                n_seg = seg7_lookup(nib);
            end
`endif
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit common-anode 7-segment scan driver
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [4*DIGITS-1:0]   DIN,
    input  logic                  EN,
    input  logic                  LZB,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     BLINK,
    output logic [6:0]            nSEG,
    output logic                  nDP,
    output logic [DIGITS-1:0]     nDIG,
    output logic                  FRAME
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;     // slot that the next tick brings up
    logic [IW-1:0]         disp_q, disp_d;   // slot currently on the display
    logic                  live_q, live_d;   // first tick seen since reset
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    logic [4*DIGITS-1:0]   sh_din_q, sh_din_d;
    logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]     sh_blink_q, sh_blink_d;
    logic                  sh_lzb_q, sh_lzb_d;
    logic [6:0]            nseg_q, nseg_d;
    logic                  ndp_q, ndp_d;
    logic [DIGITS-1:0]     ndig_q, ndig_d;
    logic                  frame_q, frame_d;

    logic                  tick, frame_start, show;
    logic                  blink_blank, lz_blank;
    logic [3:0]            nib;
    logic [6:0]            dec_seg;

    always_comb begin
        tick        = (pcnt_q == PW'(DIV - 1));
        frame_start = tick && (idx_q == '0);

        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        idx_d  = idx_q;
        disp_d = disp_q;
        if (tick) begin
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            disp_d = idx_q;
        end
        live_d = live_q | tick;

        sh_din_d   = frame_start ? DIN   : sh_din_q;
        sh_dp_d    = frame_start ? DP    : sh_dp_q;
        sh_blink_d = frame_start ? BLINK : sh_blink_q;
        sh_lzb_d   = frame_start ? LZB   : sh_lzb_q;

        // Only completed frames count toward the blink half-period
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_start && live_q) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + FW'(1);
            end
        end

        // Decode from next-state values so the guard cycle already shows the new slot
        nib         = sh_din_d[{disp_d, 2'b00} +: 4];
        blink_blank = phase_d && sh_blink_d[disp_d];
        lz_blank    = sh_lzb_d && (disp_d != '0) && ((sh_din_d >> {disp_d, 2'b00}) == '0);
        show        = live_d && EN;

        nseg_d  = show ? dec_seg : SEG_BLANK;
        ndp_d   = !(show && !blink_blank && sh_dp_d[disp_d]);
        ndig_d  = (show && (pcnt_d != '0)) ? ~(DIGITS'(1) << disp_d) : '1;
        frame_d = frame_start;
    end

    seg7_dec_core u_dec (
        .nib   (nib),
        .blank (blink_blank | lz_blank),
        .n_seg (dec_seg)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pcnt_q     <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            live_q     <= 1'b0;
            fcnt_q     <= '0;
            phase_q    <= 1'b0;
            sh_din_q   <= '0;
            sh_dp_q    <= '0;
            sh_blink_q <= '0;
            sh_lzb_q   <= 1'b0;
            nseg_q     <= SEG_BLANK;
            ndp_q      <= 1'b1;
            ndig_q     <= '1;
            frame_q    <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            live_q     <= live_d;
            fcnt_q     <= fcnt_d;
            phase_q    <= phase_d;
            sh_din_q   <= sh_din_d;
            sh_dp_q    <= sh_dp_d;
            sh_blink_q <= sh_blink_d;
            sh_lzb_q   <= sh_lzb_d;
            nseg_q     <= nseg_d;
            ndp_q      <= ndp_d;
            ndig_q     <= ndig_d;
            frame_q    <= frame_d;
        end
    end

    assign nSEG  = nseg_q;
    assign nDP   = ndp_q;
    assign nDIG  = ndig_q;
    assign FRAME = frame_q;

endmodule
